// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: canonical hex glyphs (g..a, active-high)
// used by both the segment encoder and the readback decoder.
package seg7_pkg;

   localparam int         SEG_W    = 9;
   localparam logic [6:0] SEG_MASK = 7'h7F;

   // index = hex value, entry = lit segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_CODE [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // encoder direction, kept next to the table so both sides stay in sync
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      return SEG_CODE[h];
   endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse of the hex-to-segment encoding: matches a 7-bit pattern against
// the 16 canonical glyphs. Anything else reports hit=0.
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       hit
);

   // table match; glyphs are distinct so at most one entry matches
   always_comb begin
      code = '0;
      hit  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_CODE[i]) begin
            code = 4'(i);
            hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_readback.sv
// Front-panel display readback: samples the multiplexed 7-segment bus,
// decodes each selected digit and commits a value once it has been seen
// STABLE times in a row on that digit. Unknown glyphs pulse err.
module seg7_readback
   import seg7_pkg::*;
#(
   parameter  int NDIG   = 4,
   parameter  int STABLE = 3,
   localparam int CW     = $clog2(STABLE + 1),
   localparam int EW     = (NDIG > 1) ? $clog2(NDIG) : 1
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SEG_W-1:0]     seg_in,
   input  logic [NDIG-1:0]      dig_sel,
   output logic [4*NDIG-1:0]    dig_val,
   output logic [NDIG-1:0]      dig_vld,
   output logic                 upd,
   output logic                 err,
   output logic [EW-1:0]        err_dig
);

   // dp and the spare line never affect decoding
   logic unused_bits;
   assign unused_bits = ^seg_in[SEG_W-1:7];

   logic [6:0]      s_seg;
   logic [NDIG-1:0] s_sel;

   // stage 0: register the raw bus sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_seg <= '0;
         s_sel <= '0;
      end else begin
         s_seg <= seg_in[6:0] & SEG_MASK;
         s_sel <= dig_sel;
      end
   end

   // stage 1: only an exactly one-hot select is a usable sample
   logic onehot;
   assign onehot = (s_sel != '0) && ((s_sel & (s_sel - NDIG'(1))) == '0);

   logic [EW-1:0] idx;

   // binary index of the selected digit (meaningful only when onehot)
   always_comb begin
      idx = '0;
      for (int k = 0; k < NDIG; k++)
         if (s_sel[k]) idx = idx | EW'(k);
   end

   logic [3:0] code;
   logic       hit;

   seg7_to_hex u_dec (
      .seg  (s_seg),
      .code (code),
      .hit  (hit)
   );

   logic [NDIG-1:0] chg;

   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      logic          act, commit;
      logic          cand_v, vld_q;
      logic [3:0]    cand, val_q;
      logic [CW-1:0] cnt, cnt_nxt;

      assign act = onehot & s_sel[k];

      // run length after this sample: extend a matching run, else restart at 1
      always_comb begin
         cnt_nxt = CW'(1);
         if (cand_v && (code == cand))
            cnt_nxt = (cnt == CW'(STABLE)) ? cnt : cnt + CW'(1);
      end

      // saturated repeats still commit, but the value is unchanged so no upd
      assign commit = act & hit & (cnt_nxt == CW'(STABLE));
      assign chg[k] = commit & (~vld_q | (val_q != code));

      // candidate tracking and commit; a miss drops the run but keeps the committed value
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cand   <= '0;
            cand_v <= 1'b0;
            cnt    <= '0;
            val_q  <= '0;
            vld_q  <= 1'b0;
         end else if (act) begin
            if (hit) begin
               cand   <= code;
               cand_v <= 1'b1;
               cnt    <= cnt_nxt;
               if (commit) begin
                  val_q <= code;
                  vld_q <= 1'b1;
               end
            end else begin
               cand_v <= 1'b0;
               cnt    <= '0;
            end
         end
      end

      assign dig_val[4*k +: 4] = val_q;
      assign dig_vld[k]        = vld_q;
   end

   // event pulses; one digit per cycle so upd and err are mutually exclusive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd     <= 1'b0;
         err     <= 1'b0;
         err_dig <= '0;
      end else begin
         upd     <= |chg;
         err     <= onehot & ~hit;
         err_dig <= (onehot & ~hit) ? idx : '0;
      end
   end

endmodule

// File: tb/tb_seg7_readback.sv
// Scoreboard bench for seg7_readback: stimulus pushes the hand-computed
// expected upd/err events, a negedge monitor pops and compares them.
module tb_seg7_readback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  seg_in;
   logic [3:0]  dig_sel;
   logic [15:0] dig_val;
   logic [3:0]  dig_vld;
   logic        upd, err;
   logic [1:0]  err_dig;

   seg7_readback #(.NDIG(4), .STABLE(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg_in  (seg_in),
      .dig_sel (dig_sel),
      .dig_val (dig_val),
      .dig_vld (dig_vld),
      .upd     (upd),
      .err     (err),
      .err_dig (err_dig)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      int          cyc;
      logic [15:0] val;
      logic [3:0]  vld;
      logic [1:0]  edig;
   } ev_t;

   ev_t q[$];
   ev_t e;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // apply a bus sample; it is captured on the next rising edge
   task automatic step(input logic [8:0] s, input logic [3:0] sel);
      seg_in  = s;
      dig_sel = sel;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(9'h000, 4'b0000);
   endtask

   // expected event from the sample captured at the most recent edge
   task automatic expect_ev(input bit is_err, input logic [15:0] val,
                            input logic [3:0] vld, input logic [1:0] edig);
      q.push_back('{is_err: is_err, cyc: cyc + 1, val: val, vld: vld, edig: edig});
   endtask

   // monitor: every upd/err pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (upd || err) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse upd=%0b err=%0b val=%0h at cycle %0d", upd, err, dig_val, cyc);
            end else begin
               e = q.pop_front();
               chk("ev_err",  {31'd0, err}, {31'd0, e.is_err});
               chk("ev_upd",  {31'd0, upd}, {31'd0, ~e.is_err});
               chk("ev_cyc",  cyc, e.cyc);
               chk("ev_val",  {16'd0, dig_val}, {16'd0, e.val});
               chk("ev_vld",  {28'd0, dig_vld}, {28'd0, e.vld});
               if (e.is_err) chk("err_dig", {30'd0, err_dig}, {30'd0, e.edig});
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse got none want %s at cycle %0d", e.is_err ? "err" : "upd", e.cyc);
         end
      end
   end

   logic [6:0]  pat [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};
   logic [15:0] bval[4] = '{16'h0001, 16'h0021, 16'h0321, 16'h4321};
   logic [3:0]  bvld[4] = '{4'h1, 4'h3, 4'h7, 4'hF};
   logic [6:0]  gl  [6] = '{7'h7F, 7'h7F, 7'h6F, 7'h7F, 7'h7F, 7'h7F};

   initial begin
      rst_n   = 1'b0;
      seg_in  = '0;
      dig_sel = '0;
      #12;
      chk("rst_val", {16'd0, dig_val}, 32'h0);
      chk("rst_vld", {28'd0, dig_vld}, 32'h0);
      chk("rst_upd", {31'd0, upd}, 32'h0);
      chk("rst_err", {31'd0, err}, 32'h0);
      chk("rst_err_dig", {30'd0, err_dig}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic commit: three round-robin passes showing 1,2,3,4
      for (int p = 0; p < 3; p++)
         for (int d = 0; d < 4; d++) begin
            step({2'b00, pat[d]}, 4'(1 << d));
            if (p == 2) expect_ev(1'b0, bval[d], bvld[d], 2'd0);
         end
      idle(3);
      chk("basic_val", {16'd0, dig_val}, 32'h4321);
      chk("basic_vld", {28'd0, dig_vld}, 32'hF);

      // glitch reject: a lone 9 restarts the run, 8 commits after three clean samples
      for (int i = 0; i < 6; i++) begin
         step({2'b00, gl[i]}, 4'b0001);
         if (i == 2) chk("glitch_hold", {28'd0, dig_val[3:0]}, 32'h1);
         if (i == 5) expect_ev(1'b0, 16'h4328, 4'hF, 2'd0);
      end
      idle(2);
      chk("glitch_val", {16'd0, dig_val}, 32'h4328);

      // unknown pattern on digit 2 after committing 5
      for (int i = 0; i < 3; i++) begin
         step(9'h06D, 4'b0100);
         if (i == 2) expect_ev(1'b0, 16'h4528, 4'hF, 2'd0);
      end
      step(9'h000, 4'b0100);
      expect_ev(1'b1, 16'h4528, 4'hF, 2'd2);
      idle(2);
      chk("unk_nibble", {28'd0, dig_val[11:8]}, 32'h5);
      chk("unk_vld2", {31'd0, dig_vld[2]}, 32'h1);

      // illegal selects: zero-hot and multi-hot are ignored entirely
      for (int i = 0; i < 4; i++) step(9'h03F, 4'b0000);
      for (int i = 0; i < 4; i++) step(9'h03F, 4'b0110);
      idle(2);
      chk("illegal_val", {16'd0, dig_val}, 32'h4528);
      chk("illegal_vld", {28'd0, dig_vld}, 32'hF);

      // dp and spare high, digit 1 held on 6: one commit then saturation
      for (int i = 0; i < 10; i++) begin
         step(9'h1FD, 4'b0010);
         if (i == 2) expect_ev(1'b0, 16'h4568, 4'hF, 2'd0);
      end
      idle(2);
      chk("hold_val", {16'd0, dig_val}, 32'h4568);

      // reset mid-run clears everything asynchronously
      step(9'h006, 4'b1000);
      step(9'h006, 4'b1000);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_val", {16'd0, dig_val}, 32'h0);
      chk("midrst_vld", {28'd0, dig_vld}, 32'h0);
      chk("midrst_upd", {31'd0, upd}, 32'h0);
      seg_in  = '0;
      dig_sel = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("post_rst_val", {16'd0, dig_val}, 32'h0);
      chk("post_rst_vld", {28'd0, dig_vld}, 32'h0);
      chk("post_rst_err", {31'd0, err}, 32'h0);

      chk("queue_empty", q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
